// File: rtl/tls_pkg.sv
// Shared definitions for the tls traffic-light controller and its timer front end.
// Default timing constants live here so tls and tls_timer agree on them.
package tls_pkg;

  typedef enum logic [1:0] {
    S_SHORT = 2'd0,
    S_LONG  = 2'd1,
    S_DONE  = 2'd2
  } timer_state_e;

  localparam int TLS_PRESCALE    = 10;
  localparam int TLS_SHORT_TICKS = 3;
  localparam int TLS_LONG_TICKS  = 8;
  localparam int TLS_CNT_W       = 8;
  localparam int TLS_DEB_CYCLES  = 4;
  localparam int TLS_SYNC_STAGES = 2;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tls_debounce.sv
// Synchroniser plus debounce filter: dout follows din only after din has
// held a new level for DEB_CYCLES consecutive synchronised samples.
module tls_debounce
  import tls_pkg::*;
#(
  parameter int DEB_CYCLES  = TLS_DEB_CYCLES,
  parameter int SYNC_STAGES = TLS_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int DW = ctr_width(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic [DW-1:0]          deb_cnt_reg;
  logic [DW-1:0]          deb_cnt_next;
  logic                   c_reg;
  logic                   c_next;
  logic                   s_last;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = din;
      end else begin : g_chain
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  assign s_last = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg    <= '0;
      deb_cnt_reg <= '0;
      c_reg       <= 1'b0;
    end else begin
      sync_reg    <= sync_next;
      deb_cnt_reg <= deb_cnt_next;
      c_reg       <= c_next;
    end
  end

  // Any sample agreeing with the current output restarts the stability window.
  always_comb begin
    deb_cnt_next = '0;
    c_next       = c_reg;
    if (s_last != c_reg) begin
      if (deb_cnt_reg == DEB_LAST) begin
        c_next       = ~c_reg;
        deb_cnt_next = '0;
      end else begin
        deb_cnt_next = deb_cnt_reg + 1'b1;
      end
    end
  end

  assign dout = c_reg;

  a_deb_cycles: assert property (@(posedge clk) DEB_CYCLES >= 1);
  a_sync_stages: assert property (@(posedge clk) SYNC_STAGES >= 2);

endmodule

// File: rtl/tls_timer.sv
// Interval timer and car-sensor conditioning for the tls controller.
// ST restarts the tick count; TS/TL report the short and long intervals elapsed.
module tls_timer
  import tls_pkg::*;
#(
  parameter int PRESCALE    = TLS_PRESCALE,
  parameter int SHORT_TICKS = TLS_SHORT_TICKS,
  parameter int LONG_TICKS  = TLS_LONG_TICKS,
  parameter int CNT_W       = TLS_CNT_W,
  parameter int DEB_CYCLES  = TLS_DEB_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ST,
  input  logic             car_raw,
  output logic             TS,
  output logic             TL,
  output logic             C,
  output logic             tick,
  output logic [CNT_W-1:0] count
);

  localparam int PW = ctr_width(PRESCALE);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] SHORT_TH = CNT_W'(SHORT_TICKS);
  localparam logic [CNT_W-1:0] LONG_TH  = CNT_W'(LONG_TICKS);

  logic [PW-1:0]    pre_cnt_reg;
  logic [PW-1:0]    pre_cnt_next;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  timer_state_e     state_reg;
  timer_state_e     state_next;
  logic             ts_dec;
  logic             tl_dec;

  // ST suppresses the strobe so a restart edge never also counts a tick.
  assign tick = (pre_cnt_reg == PRE_LAST) && !ST;

  always_comb begin
    pre_cnt_next = pre_cnt_reg + 1'b1;
    if (ST || pre_cnt_reg == PRE_LAST) begin
      pre_cnt_next = '0;
    end
  end

  always_comb begin
    count_next = count_reg;
    if (ST) begin
      count_next = '0;
    end else if (tick && count_reg != CNT_MAX) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt_reg <= '0;
      count_reg   <= '0;
    end else begin
      pre_cnt_reg <= pre_cnt_next;
      count_reg   <= count_next;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_SHORT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Thresholds are judged on count_next so TS/TL land on the same edge as count.
  always_comb begin
    state_next = S_SHORT;
    if (!ST) begin
      case (state_reg)
        S_SHORT: begin
          if (count_next >= LONG_TH) begin
            state_next = S_DONE;
          end else if (count_next >= SHORT_TH) begin
            state_next = S_LONG;
          end else begin
            state_next = S_SHORT;
          end
        end
        S_LONG: begin
          state_next = (count_next >= LONG_TH) ? S_DONE : S_LONG;
        end
        S_DONE: begin
          state_next = S_DONE;
        end
        default: begin
          state_next = S_SHORT;
        end
      endcase
    end
  end

  always_comb begin
    ts_dec = 1'b0;
    tl_dec = 1'b0;
    case (state_reg)
      S_LONG: begin
        ts_dec = 1'b1;
      end
      S_DONE: begin
        ts_dec = 1'b1;
        tl_dec = 1'b1;
      end
      default: begin
        ts_dec = 1'b0;
        tl_dec = 1'b0;
      end
    endcase
  end

  assign TS    = ts_dec;
  assign TL    = tl_dec;
  assign count = count_reg;

  tls_debounce #(
    .DEB_CYCLES  (DEB_CYCLES),
    .SYNC_STAGES (TLS_SYNC_STAGES)
  ) u_car_debounce (
    .clk  (clk),
    .rst  (rst),
    .din  (car_raw),
    .dout (C)
  );

  a_prescale: assert property (@(posedge clk) PRESCALE >= 1);
  a_short: assert property (@(posedge clk) SHORT_TICKS >= 1);
  a_long: assert property (@(posedge clk) LONG_TICKS > SHORT_TICKS);
  a_cnt_w: assert property (@(posedge clk) LONG_TICKS < (2 ** CNT_W));

endmodule
